// File: rtl/remote_comm.sv
// Host-side BLE command link: sends a 16-bit command as two UART frames
// (high byte first) and receives single-byte responses on RX.
module remote_comm #(
  parameter int BAUD_DIV = 5208
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  output logic        TX,
  input  logic        RX,
  output logic        busy,
  output logic        cmd_snt,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy
);

  localparam logic [12:0] BAUD_LAST = 13'(BAUD_DIV - 1);
  localparam logic [12:0] HALF_LAST = 13'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_HI, TX_LO} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HI} rx_state_e;

  tx_state_e   tx_state_q;
  logic [7:0]  cmd_lo_q;
  logic [8:0]  frame_q;
  logic        tx_q;
  logic        busy_q;
  logic        cmd_snt_q;
  logic [12:0] tx_baud_q;
  logic [3:0]  tx_bit_q;

  rx_state_e   rx_state_q;
  logic        rx_meta_q;
  logic        rx_sync_q;
  logic        rx_prev_q;
  logic [12:0] rx_baud_q;
  logic [3:0]  rx_bit_q;
  logic [7:0]  rx_shift_q;
  logic [7:0]  resp_q;
  logic        resp_rdy_q;
  logic        resp_rdy_d;

  logic        snd_acc_s;
  logic        rx_set_s;

  assign snd_acc_s = snd_cmd && (tx_state_q == TX_IDLE);
  assign rx_set_s  = (rx_state_q == RX_STOP) && (rx_baud_q == BAUD_LAST) && rx_sync_q;

  // frame_q holds the bits still to go out; a 1 shifted in becomes the stop bit
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      cmd_lo_q   <= 8'h00;
      frame_q    <= 9'h1FF;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      cmd_snt_q  <= 1'b0;
      tx_baud_q  <= 13'd0;
      tx_bit_q   <= 4'd0;
    end else begin
      cmd_snt_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: begin
          if (snd_acc_s) begin
            cmd_lo_q   <= cmd[7:0];
            frame_q    <= {1'b1, cmd[15:8]};
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            tx_baud_q  <= 13'd0;
            tx_bit_q   <= 4'd0;
            tx_state_q <= TX_HI;
          end
        end
        TX_HI, TX_LO: begin
          if (tx_baud_q == BAUD_LAST) begin
            tx_baud_q <= 13'd0;
            if (tx_bit_q == 4'd9) begin
              if (tx_state_q == TX_HI) begin
                frame_q    <= {1'b1, cmd_lo_q};
                tx_q       <= 1'b0;
                tx_bit_q   <= 4'd0;
                tx_state_q <= TX_LO;
              end else begin
                tx_q       <= 1'b1;
                busy_q     <= 1'b0;
                cmd_snt_q  <= 1'b1;
                tx_bit_q   <= 4'd0;
                tx_state_q <= TX_IDLE;
              end
            end else begin
              tx_q     <= frame_q[0];
              frame_q  <= {1'b1, frame_q[8:1]};
              tx_bit_q <= tx_bit_q + 4'd1;
            end
          end else begin
            tx_baud_q <= tx_baud_q + 13'd1;
          end
        end
        default: begin
          tx_state_q <= TX_IDLE;
          tx_q       <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // a completing frame beats any clear arriving in the same cycle
  always_comb begin
    resp_rdy_d = resp_rdy_q;
    if (rx_set_s) begin
      resp_rdy_d = 1'b1;
    end else if (clr_resp_rdy || snd_acc_s) begin
      resp_rdy_d = 1'b0;
    end else begin
      resp_rdy_d = resp_rdy_q;
    end
  end

  // receiver: double-flopped RX, mid-bit sampling, re-arms right after the stop sample
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= 13'd0;
      rx_bit_q   <= 4'd0;
      rx_shift_q <= 8'h00;
      resp_q     <= 8'h00;
      resp_rdy_q <= 1'b0;
    end else begin
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      resp_rdy_q <= resp_rdy_d;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_sync_q && rx_prev_q) begin
            rx_baud_q  <= 13'd0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_baud_q == HALF_LAST) begin
            rx_baud_q  <= 13'd0;
            rx_bit_q   <= 4'd0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_baud_q <= rx_baud_q + 13'd1;
          end
        end
        RX_DATA: begin
          if (rx_baud_q == BAUD_LAST) begin
            rx_baud_q  <= 13'd0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            if (rx_bit_q == 4'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 4'd1;
            end
          end else begin
            rx_baud_q <= rx_baud_q + 13'd1;
          end
        end
        RX_STOP: begin
          if (rx_baud_q == BAUD_LAST) begin
            rx_baud_q <= 13'd0;
            if (rx_sync_q) begin
              resp_q     <= rx_shift_q;
              rx_state_q <= RX_IDLE;
            end else begin
              rx_state_q <= RX_WAIT_HI;
            end
          end else begin
            rx_baud_q <= rx_baud_q + 13'd1;
          end
        end
        RX_WAIT_HI: begin
          if (rx_sync_q) begin
            rx_state_q <= RX_IDLE;
          end
        end
        default: begin
          rx_state_q <= RX_IDLE;
        end
      endcase
    end
  end

  assign TX       = tx_q;
  assign busy     = busy_q;
  assign cmd_snt  = cmd_snt_q;
  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm at BAUD_DIV=16: table-driven TX frames
// plus hand-written RX, collision and reset sequences.
module tb_remote_comm;

  localparam int B = 16;
  localparam int NV = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        snd_cmd;
  logic [15:0] cmd;
  logic        TX;
  logic        RX;
  logic        busy;
  logic        cmd_snt;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_resp_rdy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] cmd;
    logic [19:0] bits;
    logic        poke;
  } tx_vec_t;

  tx_vec_t vecs [NV];

  remote_comm #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst(rst), .snd_cmd(snd_cmd), .cmd(cmd), .TX(TX), .RX(RX),
    .busy(busy), .cmd_snt(cmd_snt), .resp(resp), .resp_rdy(resp_rdy),
    .clr_resp_rdy(clr_resp_rdy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // two frames, bit i is the i-th bit on the wire
  function automatic logic [19:0] frame_bits(input logic [15:0] c);
    return {1'b1, c[7:0], 1'b0, 1'b1, c[15:8], 1'b0};
  endfunction

  // snd_cmd is already high in the current cycle; runs up to the cmd_snt cycle
  task automatic run_tx(input int v, input logic chain, input logic [15:0] next_cmd);
    logic [19:0] bits;
    logic        exp_tx;
    bits = vecs[v].bits;
    for (int c = 1; c <= 20 * B + 1; c++) begin
      tick();
      if (c == 1) begin
        snd_cmd = 1'b0;
        cmd = ~cmd;
      end
      if (vecs[v].poke && c == 50) begin
        snd_cmd = 1'b1;
        cmd = 16'h1234;
      end
      if (vecs[v].poke && c == 51) snd_cmd = 1'b0;
      exp_tx = (c <= 20 * B) ? bits[(c - 1) / B] : 1'b1;
      chk("tx_bit", 32'(TX), 32'(exp_tx));
      chk("busy", 32'(busy), 32'(c <= 20 * B));
      chk("cmd_snt", 32'(cmd_snt), 32'(c == 20 * B + 1));
      if (c == 20 * B + 1 && chain) begin
        snd_cmd = 1'b1;
        cmd = next_cmd;
      end
    end
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop, input int clr_at, input logic lat_chk);
    int idx;
    for (int k = 0; k < 10 * B; k++) begin
      idx = k / B;
      RX = (idx == 0) ? 1'b0 : (idx == 9) ? stop : d[idx - 1];
      clr_resp_rdy = (k == clr_at);
      tick();
      if (lat_chk && k == 153) chk("rdy_before_lat", 32'(resp_rdy), 32'd0);
      if (lat_chk && k == 154) chk("rdy_at_lat", 32'(resp_rdy), 32'd1);
    end
    clr_resp_rdy = 1'b0;
    RX = 1'b1;
    repeat (20) tick();
  endtask

  initial begin
    vecs[0] = '{16'h2A5C, {1'b1, 8'h5C, 1'b0, 1'b1, 8'h2A, 1'b0}, 1'b0};
    vecs[1] = '{16'h0000, {1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0}, 1'b0};
    vecs[2] = '{16'hFFFF, {1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0}, 1'b0};
    vecs[3] = '{16'h8001, {1'b1, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0}, 1'b0};
    vecs[4] = '{16'hA55A, {1'b1, 8'h5A, 1'b0, 1'b1, 8'hA5, 1'b0}, 1'b1};
    vecs[5] = '{16'h1E3C, {1'b1, 8'h3C, 1'b0, 1'b1, 8'h1E, 1'b0}, 1'b0};
    for (int i = 6; i < NV; i++) begin
      vecs[i].cmd  = 16'($urandom);
      vecs[i].bits = frame_bits(vecs[i].cmd);
      vecs[i].poke = 1'b0;
    end

    rst = 1'b1;
    snd_cmd = 1'b0;
    cmd = 16'h0000;
    RX = 1'b1;
    clr_resp_rdy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_tx", 32'(TX), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_snt", 32'(cmd_snt), 32'd0);
    chk("rst_resp", 32'(resp), 32'h00);
    chk("rst_resp_rdy", 32'(resp_rdy), 32'd0);

    // back-to-back commands, each next one issued in the cmd_snt cycle
    cmd = vecs[0].cmd;
    snd_cmd = 1'b1;
    for (int v = 0; v < NV; v++) begin
      run_tx(v, v < NV - 1, (v < NV - 1) ? vecs[v + 1].cmd : 16'h0000);
    end
    repeat (5) tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_tx", 32'(TX), 32'd1);

    rx_frame(8'hA5, 1'b1, -1, 1'b1);
    chk("rx_a5_resp", 32'(resp), 32'hA5);
    chk("rx_a5_rdy", 32'(resp_rdy), 32'd1);
    clr_resp_rdy = 1'b1;
    tick();
    clr_resp_rdy = 1'b0;
    chk("clr_rdy", 32'(resp_rdy), 32'd0);
    chk("clr_resp_held", 32'(resp), 32'hA5);

    rx_frame(8'h5A, 1'b0, -1, 1'b0);
    chk("ferr_resp", 32'(resp), 32'hA5);
    chk("ferr_rdy", 32'(resp_rdy), 32'd0);

    RX = 1'b0;
    repeat (5) tick();
    RX = 1'b1;
    repeat (40) tick();
    chk("glitch_rdy", 32'(resp_rdy), 32'd0);
    chk("glitch_resp", 32'(resp), 32'hA5);

    rx_frame(8'hA5, 1'b1, -1, 1'b1);
    chk("post_glitch_rdy", 32'(resp_rdy), 32'd1);
    rx_frame(8'h3C, 1'b1, -1, 1'b0);
    chk("rx_3c_resp", 32'(resp), 32'h3C);

    clr_resp_rdy = 1'b1;
    tick();
    clr_resp_rdy = 1'b0;
    chk("clr_rdy2", 32'(resp_rdy), 32'd0);
    rx_frame(8'h5A, 1'b1, 154, 1'b1);
    chk("setwins_resp", 32'(resp), 32'h5A);

    // accepted snd_cmd clears resp_rdy, then reset lands in the low byte
    snd_cmd = 1'b1;
    cmd = 16'h0F0F;
    tick();
    snd_cmd = 1'b0;
    chk("snd_clears_rdy", 32'(resp_rdy), 32'd0);
    chk("snd_busy", 32'(busy), 32'd1);
    repeat (199) tick();
    chk("in_low_byte_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_tx", 32'(TX), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_resp", 32'(resp), 32'h00);
    for (int c = 0; c < 200; c++) begin
      tick();
      chk("midrst_no_snt", 32'(cmd_snt), 32'd0);
      chk("midrst_tx_idle", 32'(TX), 32'd1);
    end

    cmd = vecs[0].cmd;
    snd_cmd = 1'b1;
    run_tx(0, 1'b0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/remote_comm.md
# remote_comm

Host-side counterpart of the robot's BLE command link. Accepts a 16-bit command, serializes it as two UART frames (high byte first) on `TX`, and deserializes the single 8-bit response byte (0xA5 done / 0x5A in progress) returning on `RX`. Used in the full-chip testbench and in the remote controller to drive the Knight's Tour robot.

## Interface

- `BAUD_DIV`, 5208, clocks per UART bit (50 MHz / 9600 baud); minimum 8.
- `clk  input  1  system clock, all logic on rising edge`
- `rst  input  1  synchronous active-high reset`
- `snd_cmd  input  1  one-cycle request to transmit cmd; honoured only when busy=0`
- `cmd  input  16  command word, captured on accepted snd_cmd`
- `TX  output  1  UART serial out to robot RX; idle high`
- `RX  input  1  UART serial in from robot TX; asynchronous`
- `busy  output  1  high from accepted snd_cmd until cmd_snt`
- `cmd_snt  output  1  one-cycle pulse: both bytes fully sent, stop bit included`
- `resp  output  8  last correctly framed response byte`
- `resp_rdy  output  1  level: new resp available`
- `clr_resp_rdy  input  1  clears resp_rdy`

## Operation

- Reset values: `TX`=1, `busy`=0, `cmd_snt`=0, `resp`=0x00, `resp_rdy`=0; both FSMs idle, counters 0.
- Transmit FSM states: IDLE, TX_HI, TX_LO.
  - IDLE: on `snd_cmd` capture `cmd` into a 16-bit hold register, load `cmd[15:8]` into the shifter, set `busy`, go to TX_HI.
  - TX_HI: send frame of start(0), 8 data bits LSB first, stop(1). At the end of the stop bit, load `cmd[7:0]` and go to TX_LO with no idle gap.
  - TX_LO: send the same frame. At the end of the stop bit, pulse `cmd_snt`, clear `busy`, and go to IDLE.
- Frame: 10 bits, each exactly `BAUD_DIV` clocks; the baud counter restarts on every bit.
- `snd_cmd` while `busy`=1 is ignored; the held command is unaffected. Changing `cmd` after acceptance has no effect.
- Receive path runs independently of the transmit FSM and is always enabled.
  - `RX` is double-flopped before use; all decisions use the synchronized value.
  - A falling edge in idle starts a frame. The start bit is re-sampled at `BAUD_DIV/2`; if it reads 1, the frame is a false start and the receiver returns to idle.
  - Data bits are sampled at mid-bit, every `BAUD_DIV` clocks, LSB first.
  - Stop bit sampled = 1: `resp` is updated and `resp_rdy` is set.
  - Stop bit sampled = 0: framing error; byte discarded, `resp` and `resp_rdy` unchanged. The receiver waits for `RX`=1 before re-arming.
  - After a stop bit is sampled, the receiver re-arms immediately, so back-to-back frames are accepted.
- `resp_rdy` is cleared by `clr_resp_rdy` or by an accepted `snd_cmd`. If a set and a clear fall in the same cycle, set wins.
- Reset mid-frame: `TX` returns high next cycle, the partial frame is abandoned and `cmd_snt` is not pulsed.

## Timing

- Accepted `snd_cmd` in cycle N: `busy`=1 and `TX`=0 (start bit) from cycle N+1.
- High byte occupies cycles N+1 .. N+10·BAUD_DIV; low byte's start bit begins at N+10·BAUD_DIV+1.
- `cmd_snt`=1 and `busy`=0 in cycle N+20·BAUD_DIV+1. A new `snd_cmd` is accepted in that same cycle.
- RX latency: `resp_rdy` rises 2 (synchronizer) + 1 clocks after the mid-stop-bit sample point, i.e. about 9.5·BAUD_DIV+3 clocks after the `RX` falling edge.
- Counters: baud counter 13 bits, bit counter 4 bits. Wrap is never reached; both are reloaded at each boundary.

## Test plan

- BAUD_DIV=16, `snd_cmd` with `cmd`=0x2A5C -> `TX` shows 0,0x2A LSB-first,1,0,0x5C LSB-first,1; `cmd_snt` pulses exactly 321 cycles after `snd_cmd`; `busy` high 320 cycles.
- Loop `TX` into a reference UART receiver: 256 random commands, back-to-back, each issued in the `cmd_snt` cycle -> all bytes received in order with no gaps.
- Drive `RX` with frame 0xA5 -> `resp`=0xA5 and `resp_rdy`=1; `clr_resp_rdy` -> `resp_rdy`=0 next cycle, `resp` held.
- Drive `RX` with 0x5A but stop bit 0 -> `resp`/`resp_rdy` unchanged. A 0.3-bit low glitch -> no frame received. A following valid 0xA5 -> received.
- `snd_cmd` pulsed again mid-TX_HI with a different `cmd` -> ignored; the original word is sent. `clr_resp_rdy` and an RX stop-bit completion in the same cycle -> `resp_rdy`=1.
- Assert `rst` during the low byte -> `TX`=1 and `busy`=0 next cycle, no `cmd_snt`. A subsequent `snd_cmd` sends a clean frame.
